// File: rtl/cim_mvm_sequencer.sv
// Sequencer for one matrix-vector pass on the 8x8 CIM GeMM macro:
// clear the output accumulators, stream activation chunks into the
// partial-sum path, then read the eight results back as a valid/ready stream.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a command; only state with cmd_ready high
// S_CLEAR | one cycle pulsing reset_output to zero the accumulators
// S_ACCUM | one activation beat per chunk, row = base + 8*k (wraps)
// S_READ  | presenting result rd_idx via output_reg, advancing on ready
// S_DONE  | one-cycle done pulse, then back to idle
module cim_mvm_sequencer #(
    parameter int ROW_AW = 7,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ROW_AW-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_chunks,
    input  logic              cmd_relu,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [31:0]       act_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [2:0]        res_idx,
    output logic              res_last,
    output logic              done,
    output logic              cim_cs,
    output logic              cim_write,
    output logic              cim_en,
    output logic              cim_partial_sum,
    output logic              cim_reset_output,
    output logic [3:0]        cim_output_reg,
    output logic [31:0]       cim_address,
    output logic [31:0]       cim_input_data,
    input  logic [31:0]       cim_output
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_READ,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ROW_AW-1:0]  r_base;
    logic [CNT_W-1:0]   r_chunks;
    logic               r_relu;
    logic [CNT_W-1:0]   r_k;
    logic [2:0]         r_rd_idx;
    logic [ROW_AW-1:0]  w_row;
    logic               w_last_chunk;

    // Chunk k lives eight rows above chunk k-1; the sum wraps inside the bank.
    assign w_row        = r_base + ROW_AW'({r_k, 3'b000});
    assign w_last_chunk = (r_k == (r_chunks - CNT_W'(1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, chunk counter and read index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_chunks <= '0;
            r_relu   <= 1'b0;
            r_k      <= '0;
            r_rd_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_base   <= cmd_base;
                        r_chunks <= cmd_chunks;
                        r_relu   <= cmd_relu;
                        r_k      <= '0;
                        r_rd_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    if (act_valid) begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                S_READ: begin
                    // Wraps 7 -> 0 so the index is back at 0 for the next command.
                    if (res_ready) begin
                        r_rd_idx <= r_rd_idx + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and all macro / stream outputs.
    always_comb begin
        w_state_nxt      = r_state;
        cmd_ready        = 1'b0;
        act_ready        = 1'b0;
        res_valid        = 1'b0;
        res_data         = '0;
        res_idx          = '0;
        res_last         = 1'b0;
        done             = 1'b0;
        cim_cs           = 1'b0;
        cim_write        = 1'b0;
        cim_en           = 1'b0;
        cim_partial_sum  = 1'b0;
        cim_reset_output = 1'b0;
        cim_output_reg   = '0;
        cim_address      = '0;
        cim_input_data   = '0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cim_cs           = 1'b1;
                cim_en           = 1'b1;
                cim_reset_output = 1'b1;
                w_state_nxt      = (r_chunks != '0) ? S_ACCUM : S_READ;
            end
            S_ACCUM: begin
                // Chip select follows act_valid so a stalled cycle leaves the
                // accumulators untouched.
                act_ready       = 1'b1;
                cim_cs          = act_valid;
                cim_en          = 1'b1;
                cim_partial_sum = 1'b1;
                cim_address     = {{(32-ROW_AW){1'b0}}, w_row};
                cim_input_data  = act_data;
                if (act_valid && w_last_chunk) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                cim_en         = 1'b1;
                cim_output_reg = {1'b0, r_rd_idx};
                res_valid      = 1'b1;
                res_data       = (r_relu && cim_output[31]) ? 32'd0 : cim_output;
                res_idx        = r_rd_idx;
                res_last       = (r_rd_idx == 3'd7);
                if (res_ready && (r_rd_idx == 3'd7)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cim_mvm_sequencer.sv
// Directed bench for cim_mvm_sequencer with a small behavioural macro model:
// each output channel j owns a 6-bit accumulator; a partial-sum write at
// address a adds activation nibble j when row (a+j) mod 128 holds a weight.
module tb_cim_mvm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_base;
    logic [4:0]  cmd_chunks;
    logic        cmd_relu;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_idx;
    logic        res_last;
    logic        done;
    logic        cim_cs;
    logic        cim_write;
    logic        cim_en;
    logic        cim_partial_sum;
    logic        cim_reset_output;
    logic [3:0]  cim_output_reg;
    logic [31:0] cim_address;
    logic [31:0] cim_input_data;
    logic [31:0] cim_output;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [5:0]  acc  [8] = '{default: 6'd0};
    logic        wmem [128];
    logic [5:0]  w_sel;
    logic [31:0] e_arr [8];

    cim_mvm_sequencer #(.ROW_AW(7), .CNT_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_base         (cmd_base),
        .cmd_chunks       (cmd_chunks),
        .cmd_relu         (cmd_relu),
        .act_valid        (act_valid),
        .act_ready        (act_ready),
        .act_data         (act_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_idx          (res_idx),
        .res_last         (res_last),
        .done             (done),
        .cim_cs           (cim_cs),
        .cim_write        (cim_write),
        .cim_en           (cim_en),
        .cim_partial_sum  (cim_partial_sum),
        .cim_reset_output (cim_reset_output),
        .cim_output_reg   (cim_output_reg),
        .cim_address      (cim_address),
        .cim_input_data   (cim_input_data),
        .cim_output       (cim_output)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Macro model; it has no reset, like the real accumulators.
    always @(posedge clk) begin
        if (cim_cs && cim_en) begin
            if (cim_reset_output) begin
                for (int j = 0; j < 8; j++) acc[j] <= 6'd0;
            end else if (cim_partial_sum) begin
                for (int j = 0; j < 8; j++) begin
                    if (wmem[cim_address[6:0] + 7'(j)])
                        acc[j] <= acc[j] + 6'(cim_input_data[31-4*j -: 4]);
                end
            end
        end
    end

    assign w_sel      = acc[cim_output_reg[2:0]];
    assign cim_output = {{26{w_sel[5]}}, w_sel};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue a command and check the CLEAR cycle; returns at the first cycle after CLEAR.
    task automatic send_cmd(input logic [6:0] base, input logic [4:0] n, input logic relu,
                            output int c0);
        cmd_base   = base;
        cmd_chunks = n;
        cmd_relu   = relu;
        cmd_valid  = 1'b1;
        #1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        c0 = cyc;
        #1;
        chk("clr_reset_output", {31'd0, cim_reset_output}, 32'd1);
        chk("clr_cs_en_ps_wr", {28'd0, cim_cs, cim_en, cim_partial_sum, cim_write}, 32'hC);
        chk("clr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
    endtask

    // Drive n beats of all-ones activations with 'stall' idle cycles between beats.
    task automatic feed(input int n, input int stall, input logic [6:0] base);
        logic [6:0] a;
        for (int b = 0; b < n; b++) begin
            a         = base + 7'(8 * b);
            act_valid = 1'b1;
            act_data  = 32'hFFFF_FFFF;
            #1;
            chk("act_ready", {31'd0, act_ready}, 32'd1);
            chk("beat_cs_ps", {30'd0, cim_cs, cim_partial_sum}, 32'd3);
            chk("beat_addr", cim_address, {25'd0, a});
            chk("beat_data", cim_input_data, 32'hFFFF_FFFF);
            @(negedge clk);
            act_valid = 1'b0;
            if (b < n - 1) begin
                for (int s = 0; s < stall; s++) begin
                    #1;
                    chk("stall_cs", {31'd0, cim_cs}, 32'd0);
                    chk("stall_addr", cim_address, {25'd0, 7'(a + 7'd8)});
                    @(negedge clk);
                end
            end
        end
        #1;
        chk("act_ready_after", {31'd0, act_ready}, 32'd0);
    endtask

    // Collect eight results; done_cyc < 0 skips the latency check.
    task automatic get_results(input int done_cyc, input bit gappy);
        int idx   = 0;
        int guard = 0;
        while (idx < 8 && guard < 60) begin
            res_ready = gappy ? guard[0] : 1'b1;
            #1;
            if (res_valid && res_ready) begin
                chk("res_data", res_data, e_arr[idx]);
                chk("res_idx", {29'd0, res_idx}, 32'(idx));
                chk("res_last", {31'd0, res_last}, {31'd0, (idx == 7)});
                chk("out_reg", {28'd0, cim_output_reg}, 32'(idx));
                idx++;
            end else if (res_valid) begin
                chk("hold_idx", {29'd0, res_idx}, 32'(idx));
                chk("hold_data", res_data, e_arr[idx]);
            end
            @(negedge clk);
            guard++;
        end
        if (idx < 8) chk("res_timeout", 32'(idx), 32'd8);
        res_ready = 1'b0;
        #1;
        chk("done", {31'd0, done}, 32'd1);
        if (done_cyc >= 0) chk("done_cycle", 32'(cyc), 32'(done_cyc));
        @(negedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 8; i++) e_arr[i] = v;
    endtask

    initial begin
        int c0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_base   = '0;
        cmd_chunks = '0;
        cmd_relu   = 1'b0;
        act_valid  = 1'b0;
        act_data   = '0;
        res_ready  = 1'b0;
        for (int r = 0; r < 128; r++) wmem[r] = (r < 24);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_ctrl", {23'd0, act_ready, res_valid, res_last, done, cim_cs, cim_write,
                         cim_en, cim_partial_sum, cim_reset_output}, 32'd0);
        chk("rst_addr", cim_address, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single chunk, free-running ready.
        send_cmd(7'd0, 5'd1, 1'b0, c0);
        feed(1, 0, 7'd0);
        fill(32'h0000_000F);
        get_results(c0 + 10, 1'b0);

        // Two chunks with three stall cycles, ready toggling.
        send_cmd(7'd0, 5'd2, 1'b0, c0);
        feed(2, 3, 7'd0);
        fill(32'h0000_001E);
        get_results(-1, 1'b1);

        // Three chunks: 45 in 6 bits is -19.
        send_cmd(7'd0, 5'd3, 1'b0, c0);
        feed(3, 0, 7'd0);
        fill(32'hFFFF_FFED);
        get_results(c0 + 12, 1'b0);

        // Same with ReLU.
        send_cmd(7'd0, 5'd3, 1'b1, c0);
        feed(3, 0, 7'd0);
        fill(32'h0000_0000);
        get_results(c0 + 12, 1'b0);

        // Base 124: rows 124..127 are empty, rows 0..3 loaded.
        send_cmd(7'd124, 5'd1, 1'b0, c0);
        feed(1, 0, 7'd124);
        for (int i = 0; i < 8; i++) e_arr[i] = (i < 4) ? 32'd0 : 32'h0000_000F;
        get_results(c0 + 10, 1'b0);

        // Zero chunks: straight from CLEAR to READ.
        send_cmd(7'd0, 5'd0, 1'b0, c0);
        #1;
        chk("zero_act_ready", {31'd0, act_ready}, 32'd0);
        chk("zero_res_valid", {31'd0, res_valid}, 32'd1);
        fill(32'd0);
        get_results(c0 + 9, 1'b0);

        // Reset during beat 2 of 3.
        send_cmd(7'd0, 5'd3, 1'b0, c0);
        act_valid = 1'b1;
        act_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("mid_beat2_cs", {31'd0, cim_cs}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_ctrl", {23'd0, act_ready, res_valid, res_last, done, cim_cs, cim_write,
                             cim_en, cim_partial_sum, cim_reset_output}, 32'd0);
        chk("mid_rst_addr", cim_address, 32'd0);
        @(negedge clk);
        act_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        send_cmd(7'd0, 5'd1, 1'b0, c0);
        feed(1, 0, 7'd0);
        fill(32'h0000_000F);
        get_results(c0 + 10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
